aes_round_sequencer: RTL and testbench

- Iterative AES round controller and state register.
- Accepts one 128-bit block over a valid/ready handshake and applies initial AddRoundKey.
- Steps the round counter 1..NUM_ROUNDS, each cycle selecting the full-round result (middle rounds) or the final-round result (last round), then XORing the round key.
- Returns the result over a valid/ready handshake. SubBytes/ShiftRows/MixColumns logic and the key schedule are external combinational blocks driven from state_q and Round_Number.

---
 rtl/aes_round_sequencer.sv | 117 +++++++++++
 tb/tb_aes_round_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_sequencer
// Description : Iterative AES round controller and 128-bit state register.
//               Round datapath and key schedule are external combinational
//               blocks driven from state_q and Round_Number.
// Revision    : 1.0 - initial release
// ============================================================================

module aes_round_sequencer #(
    parameter int SENTENCE   = 128,
    parameter int NUM_ROUNDS = 10,
    parameter int RW         = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SENTENCE-1:0] in_data,
    input  logic [SENTENCE-1:0] round_key,
    input  logic [SENTENCE-1:0] round_full,
    input  logic [SENTENCE-1:0] round_final,
    output logic [SENTENCE-1:0] state_q,
    output logic [RW-1:0]       Round_Number,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SENTENCE-1:0] out_data
);

    if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : g_bad_num_rounds
        $error("aes_round_sequencer: NUM_ROUNDS must be 10, 12 or 14");
    end

    if ((2 ** RW) <= NUM_ROUNDS) begin : g_bad_rw
        $error("aes_round_sequencer: RW too narrow for NUM_ROUNDS");
    end

    localparam logic [RW-1:0] LAST_ROUND  = RW'(NUM_ROUNDS);
    localparam logic [RW-1:0] FIRST_ROUND = RW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t                fsm_state;
    fsm_t                fsm_next;
    logic [SENTENCE-1:0] state_next;
    logic [RW-1:0]       round_next;
    logic                round_is_last;
    logic                round_is_middle;

    assign round_is_last   = (Round_Number == LAST_ROUND);
    assign round_is_middle = (Round_Number != '0) && (Round_Number < LAST_ROUND);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state    <= IDLE;
            state_q      <= '0;
            Round_Number <= '0;
        end else begin
            fsm_state    <= fsm_next;
            state_q      <= state_next;
            Round_Number <= round_next;
        end
    end

    // Any round index outside the legal window for the current state (only
    // reachable through an upset) drops the FSM back to IDLE.
    always_comb begin
        fsm_next   = fsm_state;
        state_next = state_q;
        round_next = Round_Number;
        case (fsm_state)
            IDLE: begin
                round_next = '0;
                if (in_valid) begin
                    state_next = in_data ^ round_key;
                    round_next = FIRST_ROUND;
                    fsm_next   = ROUND;
                end
            end
            ROUND: begin
                if (round_is_last) begin
                    state_next = round_final ^ round_key;
                    fsm_next   = DONE;
                end else if (round_is_middle) begin
                    state_next = round_full ^ round_key;
                    round_next = Round_Number + RW'(1);
                end else begin
                    fsm_next   = IDLE;
                    round_next = '0;
                end
            end
            DONE: begin
                if (out_ready || !round_is_last) begin
                    fsm_next   = IDLE;
                    round_next = '0;
                end
            end
            default: begin
                fsm_next   = IDLE;
                round_next = '0;
            end
        endcase
    end

    assign in_ready  = (fsm_state == IDLE);
    assign busy      = (fsm_state == ROUND);
    assign out_valid = (fsm_state == DONE);
    assign out_data  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// Testbench for aes_round_sequencer: drives a behavioural AES round function
// and key schedule around two instances (10 and 14 rounds).
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    logic [7:0]   sbox [0:255];
    logic [31:0]  kw   [0:59];
    logic [127:0] rk10 [0:15];
    logic [127:0] rk14 [0:15];
    logic         stub;

    logic         iv10, ir10, or10, ov10, busy10;
    logic [127:0] id10, key10, full10, fin10, sq10, od10;
    logic [3:0]   rn10;

    logic         iv14, ir14, or14, ov14, busy14;
    logic [127:0] id14, key14, full14, fin14, sq14, od14;
    logic [3:0]   rn14;

    // ---------------- behavioural AES (FIPS-197) ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox[s[127-8*(r+4*((c+r)%4)) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_full(input logic [127:0] s);
        return mix(sub_shift(s));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) kw[i] = '0;
        for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = kw[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            kw[i] = kw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] rkw(input int r);
        return {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ rkw(0);
        for (int r = 1; r < nr; r++) s = aes_full(s) ^ rkw(r);
        return sub_shift(s) ^ rkw(nr);
    endfunction

    task automatic load_rk10();
        for (int r = 0; r < 16; r++) rk10[r] = (r <= 10) ? rkw(r) : '0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- external round logic around the DUTs ----------------
    assign key10  = stub ? '0 : rk10[rn10];
    assign full10 = stub ? sq10 + 128'd1  : aes_full(sq10);
    assign fin10  = stub ? sq10 + 128'd16 : sub_shift(sq10);

    assign key14  = rk14[rn14];
    assign full14 = aes_full(sq14);
    assign fin14  = sub_shift(sq14);

    aes_round_sequencer #(.SENTENCE(128), .NUM_ROUNDS(10), .RW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(iv10), .in_ready(ir10), .in_data(id10),
        .round_key(key10), .round_full(full10), .round_final(fin10),
        .state_q(sq10), .Round_Number(rn10), .busy(busy10),
        .out_valid(ov10), .out_ready(or10), .out_data(od10)
    );

    aes_round_sequencer #(.SENTENCE(128), .NUM_ROUNDS(14), .RW(4)) dut14 (
        .clk(clk), .rst(rst), .in_valid(iv14), .in_ready(ir14), .in_data(id14),
        .round_key(key14), .round_full(full14), .round_final(fin14),
        .state_q(sq14), .Round_Number(rn14), .busy(busy14),
        .out_valid(ov14), .out_ready(or14), .out_data(od14)
    );

    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    // ---------------- drive helpers (no comparisons) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send10(input logic [127:0] pt);
        int n;
        n    = 0;
        id10 = pt;
        iv10 = 1'b1;
        while (!ir10 && n < 50) begin
            tick();
            n++;
        end
        tick();
        iv10 = 1'b0;
    endtask

    // Edges from the acceptance edge until out_valid is first seen.
    task automatic wait_out10(output int n);
        n = 0;
        while (!ov10 && n < 100) begin
            tick();
            n++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst  = 1'b1;
        iv10 = 1'b1;
        id10 = rand128();
        tick();
        tick();
        checks++; if (ir10 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ir10); else passes++;
        checks++; if (busy10 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy10); else passes++;
        checks++; if (ov10 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov10); else passes++;
        checks++; if (rn10 !== 4'd0) $display("FAIL reset_round: got %0d want 0", rn10); else passes++;
        checks++; if (sq10 !== 128'h0) $display("FAIL reset_state: got %h want 0", sq10); else passes++;
        rst  = 1'b0;
        iv10 = 1'b0;
        tick();
    endtask

    task automatic test_fips128();
        int n;
        stub = 1'b0;
        expand_key(KEY128, 4);
        load_rk10();
        or10 = 1'b1;
        send10(PT);
        wait_out10(n);
        checks++; if (n !== 10) $display("FAIL fips128_latency: got %0d edges want 10", n); else passes++;
        checks++; if (od10 !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
            $display("FAIL fips128_data: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", od10); else passes++;
        checks++; if (ir10 !== 1'b0 || busy10 !== 1'b0)
            $display("FAIL fips128_done_flags: in_ready=%b busy=%b want 0 0", ir10, busy10); else passes++;
        tick();
        checks++; if (ov10 !== 1'b0 || ir10 !== 1'b1)
            $display("FAIL fips128_release: out_valid=%b in_ready=%b want 0 1", ov10, ir10); else passes++;
    endtask

    task automatic test_stub_final_round();
        int n;
        stub = 1'b1;
        or10 = 1'b1;
        send10(128'h0);
        wait_out10(n);
        checks++; if (n !== 10) $display("FAIL stub_latency: got %0d want 10", n); else passes++;
        checks++; if (od10 !== 128'h19) $display("FAIL stub_data: got %h want 19", od10); else passes++;
        tick();
        stub = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        logic [127:0] pa, pb, ea, eb;
        pa = rand128();
        pb = rand128();
        ea = model_encrypt(pa, 10);
        eb = model_encrypt(pb, 10);
        or10 = 1'b0;
        send10(pa);
        wait_out10(n);
        checks++; if (od10 !== ea) $display("FAIL bp_first_data: got %h want %h", od10, ea); else passes++;
        id10 = pb;
        iv10 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({ov10, ir10, rn10, od10} !== {1'b1, 1'b0, 4'd10, ea})
                $display("FAIL bp_hold[%0d]: ov=%b rdy=%b rn=%0d data=%h want 1 0 10 %h",
                         i, ov10, ir10, rn10, od10, ea);
            else passes++;
        end
        or10 = 1'b1;
        tick();
        checks++; if ({ir10, ov10, rn10} !== {1'b1, 1'b0, 4'd0})
            $display("FAIL bp_release: rdy=%b ov=%b rn=%0d want 1 0 0", ir10, ov10, rn10); else passes++;
        tick();
        iv10 = 1'b0;
        wait_out10(n);
        checks++; if (n !== 10) $display("FAIL bp_second_latency: got %0d want 10", n); else passes++;
        checks++; if (od10 !== eb) $display("FAIL bp_second_data: got %h want %h", od10, eb); else passes++;
        tick();
    endtask

    task automatic test_reset_mid_round();
        int  n;
        bit  seen;
        or10 = 1'b1;
        send10(rand128());
        n = 0;
        while (rn10 !== 4'd5 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (rn10 !== 4'd5) $display("FAIL abort_reach_r5: got %0d want 5", rn10); else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({sq10, rn10, ir10, busy10, ov10} !== {128'h0, 4'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL abort_state: state=%h rn=%0d rdy=%b busy=%b ov=%b want 0 0 1 0 0",
                     sq10, rn10, ir10, busy10, ov10);
        else passes++;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ov10 || rn10 != 4'd0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL abort_no_output: got %b want 0", seen); else passes++;
    endtask

    task automatic test_random_blocks();
        int n;
        int d;
        logic [127:0] pt, ex;
        for (int k = 0; k < 6; k++) begin
            expand_key({rand128(), 128'h0}, 4);
            load_rk10();
            pt   = rand128();
            ex   = model_encrypt(pt, 10);
            d    = $urandom_range(0, 3);
            or10 = 1'b0;
            send10(pt);
            wait_out10(n);
            checks++; if (n !== 10) $display("FAIL rand_latency[%0d]: got %0d want 10", k, n); else passes++;
            checks++; if (od10 !== ex) $display("FAIL rand_data[%0d]: got %h want %h", k, od10, ex); else passes++;
            for (int i = 0; i < d; i++) tick();
            or10 = 1'b1;
            tick();
            checks++; if (ov10 !== 1'b0) $display("FAIL rand_release[%0d]: ov=%b want 0", k, ov10); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int n, m;
        logic [127:0] pts [5];
        logic [127:0] exs [5];
        int acc [5];
        for (int k = 0; k < 5; k++) begin
            pts[k] = rand128();
            exs[k] = model_encrypt(pts[k], 10);
        end
        or10 = 1'b1;
        iv10 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            id10 = pts[k];
            n = 0;
            while (!ir10 && n < 40) begin
                tick();
                n++;
            end
            tick();
            acc[k] = cyc;
            wait_out10(m);
            checks++; if (od10 !== exs[k]) $display("FAIL b2b_data[%0d]: got %h want %h", k, od10, exs[k]); else passes++;
            if (k > 0) begin
                checks++;
                if (acc[k] - acc[k-1] !== 12)
                    $display("FAIL b2b_interval[%0d]: got %0d want 12", k, acc[k] - acc[k-1]);
                else passes++;
            end
            tick();
        end
        iv10 = 1'b0;
        tick();
    endtask

    task automatic test_fips256_rounds();
        int exp_rn;
        expand_key(KEY256, 8);
        for (int r = 0; r < 16; r++) rk14[r] = (r <= 14) ? rkw(r) : '0;
        or14 = 1'b0;
        id14 = PT;
        iv14 = 1'b1;
        checks++; if ({ir14, rn14} !== {1'b1, 4'd0}) $display("FAIL r14_idle: rdy=%b rn=%0d want 1 0", ir14, rn14); else passes++;
        tick();
        iv14 = 1'b0;
        checks++; if ({rn14, busy14} !== {4'd1, 1'b1}) $display("FAIL r14_start: rn=%0d busy=%b want 1 1", rn14, busy14); else passes++;
        for (int j = 1; j <= 18; j++) begin
            tick();
            exp_rn = (j + 1 > 14) ? 14 : j + 1;
            checks++;
            if ({rn14, ov14} !== {4'(exp_rn), (j >= 14)})
                $display("FAIL r14_seq[%0d]: rn=%0d ov=%b want %0d %b", j, rn14, ov14, exp_rn, (j >= 14));
            else passes++;
        end
        checks++; if (od14 !== 128'h8ea2b7ca516745bfeafc49904b496089)
            $display("FAIL r14_data: got %h want 8ea2b7ca516745bfeafc49904b496089", od14); else passes++;
        or14 = 1'b1;
        tick();
        checks++; if ({ir14, ov14, rn14} !== {1'b1, 1'b0, 4'd0})
            $display("FAIL r14_release: rdy=%b ov=%b rn=%0d want 1 0 0", ir14, ov14, rn14); else passes++;
    endtask

    initial begin
        rst  = 1'b1;
        stub = 1'b0;
        iv10 = 1'b0; or10 = 1'b1; id10 = '0;
        iv14 = 1'b0; or14 = 1'b1; id14 = '0;
        for (int r = 0; r < 16; r++) begin
            rk10[r] = '0;
            rk14[r] = '0;
        end
        init_sbox();
        test_reset();
        test_fips128();
        test_stub_final_round();
        test_backpressure();
        test_reset_mid_round();
        test_random_blocks();
        test_back_to_back();
        test_fips256_rounds();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
